// File: rtl/control_unit_top.sv
// -----------------------------------------------------------------------------
// control_unit_top
//
// Main decoder plus ALU-control decoder for an RV32I-style datapath. Decodes
// opcode/funct3/funct7 into datapath enables, ALU operation, next-PC source and
// immediate format, and flags instructions that cannot be decoded. Any
// undecodable instruction forces every decode output to the NOP value.
//
// Build option:
//   CTRL_OUTREG_EN  defined   -> all decode outputs and `illegal` are registered
//                                (one-cycle latency, cleared to NOP by reset).
//                   undefined -> decode outputs are purely combinational.
//   illegal_sticky is registered in both builds.
//
// Ports:
//   clk            in   rising-edge clock
//   rst_n          in   asynchronous active-low reset
//   opcode[6:0]    in   instr[6:0]
//   funct3[2:0]    in   instr[14:12]
//   funct7[6:0]    in   instr[31:25]
//   instr_valid    in   qualifies the instruction for sticky illegal tracking
//   reg_write, mem_read, mem_write, mem_to_reg, branch, alu_src
//                  out  datapath enables/selects
//   alu_op[1:0]    out  00 add, 01 branch-compare, 10 R-type, 11 I-type ALU
//   alu_ctrl[3:0]  out  ALU function select (see ALU_* constants)
//   pc_src[1:0]    out  00 PC+4, 01 PC+imm, 10 ALU result
//   imm_type[2:0]  out  000 I, 001 S, 010 B, 011 U, 100 J, 111 none
//   illegal        out  current instruction not decodable
//   illegal_sticky out  latched illegal flag, cleared only by reset
// -----------------------------------------------------------------------------
module control_unit_top (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    input  logic       instr_valid,
    output logic       reg_write,
    output logic       mem_read,
    output logic       mem_write,
    output logic       mem_to_reg,
    output logic       branch,
    output logic       alu_src,
    output logic [1:0] alu_op,
    output logic [3:0] alu_ctrl,
    output logic [1:0] pc_src,
    output logic [2:0] imm_type,
    output logic       illegal,
    output logic       illegal_sticky
);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_XOR  = 4'b0011;
    localparam logic [3:0] ALU_SLL  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLT  = 4'b0111;
    localparam logic [3:0] ALU_SRA  = 4'b1000;
    localparam logic [3:0] ALU_SLTU = 4'b1001;

    localparam logic [6:0] F7_ZERO = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    logic       reg_write_next, mem_read_next, mem_write_next, mem_to_reg_next;
    logic       branch_next, alu_src_next, illegal_next;
    logic [1:0] alu_op_next, pc_src_next;
    logic [3:0] alu_ctrl_next;
    logic [2:0] imm_type_next;
    logic       sticky_reg;

    always_comb begin
        reg_write_next  = 1'b0;
        mem_read_next   = 1'b0;
        mem_write_next  = 1'b0;
        mem_to_reg_next = 1'b0;
        branch_next     = 1'b0;
        alu_src_next    = 1'b0;
        alu_op_next     = 2'b00;
        alu_ctrl_next   = ALU_ADD;
        pc_src_next     = 2'b00;
        imm_type_next   = 3'b111;
        illegal_next    = 1'b0;

        case (opcode)
            OP_R: begin
                reg_write_next = 1'b1;
                alu_op_next    = 2'b10;
                // Only SUB and SRA use the alternate funct7 encoding.
                if (funct7 == F7_ALT)
                    illegal_next = (funct3 != 3'b000) && (funct3 != 3'b101);
                else if (funct7 != F7_ZERO)
                    illegal_next = 1'b1;
            end
            OP_LOAD: begin
                reg_write_next  = 1'b1;
                mem_read_next   = 1'b1;
                mem_to_reg_next = 1'b1;
                alu_src_next    = 1'b1;
                imm_type_next   = 3'b000;
                illegal_next    = (funct3 == 3'b011) || (funct3 == 3'b110) ||
                                  (funct3 == 3'b111);
            end
            OP_STORE: begin
                mem_write_next = 1'b1;
                alu_src_next   = 1'b1;
                imm_type_next  = 3'b001;
                illegal_next   = (funct3 > 3'b010);
            end
            OP_BRANCH: begin
                branch_next   = 1'b1;
                alu_op_next   = 2'b01;
                pc_src_next   = 2'b01;
                imm_type_next = 3'b010;
                illegal_next  = (funct3 == 3'b010) || (funct3 == 3'b011);
            end
            OP_IMM: begin
                reg_write_next = 1'b1;
                alu_src_next   = 1'b1;
                alu_op_next    = 2'b11;
                imm_type_next  = 3'b000;
                // funct7 is immediate payload except for the shift forms.
                if (funct3 == 3'b001)
                    illegal_next = (funct7 != F7_ZERO);
                else if (funct3 == 3'b101)
                    illegal_next = (funct7 != F7_ZERO) && (funct7 != F7_ALT);
            end
            OP_JAL: begin
                reg_write_next = 1'b1;
                pc_src_next    = 2'b01;
                imm_type_next  = 3'b100;
            end
            OP_JALR: begin
                reg_write_next = 1'b1;
                alu_src_next   = 1'b1;
                pc_src_next    = 2'b10;
                imm_type_next  = 3'b000;
                illegal_next   = (funct3 != 3'b000);
            end
            OP_LUI, OP_AUIPC: begin
                reg_write_next = 1'b1;
                alu_src_next   = 1'b1;
                imm_type_next  = 3'b011;
            end
            default: illegal_next = 1'b1;
        endcase

        case (alu_op_next)
            2'b01: begin
                case (funct3)
                    3'b000, 3'b001: alu_ctrl_next = ALU_SUB;
                    3'b100, 3'b101: alu_ctrl_next = ALU_SLT;
                    3'b110, 3'b111: alu_ctrl_next = ALU_SLTU;
                    default:        alu_ctrl_next = ALU_ADD;
                endcase
            end
            2'b10, 2'b11: begin
                case (funct3)
                    // For I-type funct7 is immediate data, so never SUB.
                    3'b000:  alu_ctrl_next = (alu_op_next == 2'b10 && funct7[5]) ?
                                             ALU_SUB : ALU_ADD;
                    3'b001:  alu_ctrl_next = ALU_SLL;
                    3'b010:  alu_ctrl_next = ALU_SLT;
                    3'b011:  alu_ctrl_next = ALU_SLTU;
                    3'b100:  alu_ctrl_next = ALU_XOR;
                    3'b101:  alu_ctrl_next = funct7[5] ? ALU_SRA : ALU_SRL;
                    3'b110:  alu_ctrl_next = ALU_OR;
                    default: alu_ctrl_next = ALU_AND;
                endcase
            end
            default: alu_ctrl_next = ALU_ADD;
        endcase

        // Undecodable instructions must not disturb the datapath.
        if (illegal_next) begin
            reg_write_next  = 1'b0;
            mem_read_next   = 1'b0;
            mem_write_next  = 1'b0;
            mem_to_reg_next = 1'b0;
            branch_next     = 1'b0;
            alu_src_next    = 1'b0;
            alu_op_next     = 2'b00;
            alu_ctrl_next   = ALU_ADD;
            pc_src_next     = 2'b00;
            imm_type_next   = 3'b111;
        end
    end

`ifdef CTRL_OUTREG_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reg_write  <= 1'b0;
            mem_read   <= 1'b0;
            mem_write  <= 1'b0;
            mem_to_reg <= 1'b0;
            branch     <= 1'b0;
            alu_src    <= 1'b0;
            alu_op     <= 2'b00;
            alu_ctrl   <= ALU_ADD;
            pc_src     <= 2'b00;
            imm_type   <= 3'b111;
            illegal    <= 1'b0;
        end else begin
            reg_write  <= reg_write_next;
            mem_read   <= mem_read_next;
            mem_write  <= mem_write_next;
            mem_to_reg <= mem_to_reg_next;
            branch     <= branch_next;
            alu_src    <= alu_src_next;
            alu_op     <= alu_op_next;
            alu_ctrl   <= alu_ctrl_next;
            pc_src     <= pc_src_next;
            imm_type   <= imm_type_next;
            illegal    <= illegal_next;
        end
    end
`else
    assign reg_write  = reg_write_next;
    assign mem_read   = mem_read_next;
    assign mem_write  = mem_write_next;
    assign mem_to_reg = mem_to_reg_next;
    assign branch     = branch_next;
    assign alu_src    = alu_src_next;
    assign alu_op     = alu_op_next;
    assign alu_ctrl   = alu_ctrl_next;
    assign pc_src     = pc_src_next;
    assign imm_type   = imm_type_next;
    assign illegal    = illegal_next;
`endif

    // Samples the combinational decode so both builds latch on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            sticky_reg <= 1'b0;
        else if (instr_valid && illegal_next)
            sticky_reg <= 1'b1;
    end

    assign illegal_sticky = sticky_reg;

endmodule

// File: tb/tb_control_unit_top.sv
// -----------------------------------------------------------------------------
// tb_control_unit_top
//
// Table-driven check of control_unit_top decode, followed by hand-written
// sequences for sticky illegal tracking, asynchronous reset and output latency.
// Works in both builds (CTRL_OUTREG_EN defined or not).
// -----------------------------------------------------------------------------
module tb_control_unit_top;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       instr_valid;
    logic       reg_write, mem_read, mem_write, mem_to_reg, branch, alu_src;
    logic [1:0] alu_op;
    logic [3:0] alu_ctrl;
    logic [1:0] pc_src;
    logic [2:0] imm_type;
    logic       illegal, illegal_sticky;

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    control_unit_top dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3), .funct7(funct7),
        .instr_valid(instr_valid), .reg_write(reg_write), .mem_read(mem_read),
        .mem_write(mem_write), .mem_to_reg(mem_to_reg), .branch(branch),
        .alu_src(alu_src), .alu_op(alu_op), .alu_ctrl(alu_ctrl), .pc_src(pc_src),
        .imm_type(imm_type), .illegal(illegal), .illegal_sticky(illegal_sticky)
    );

    // Packed as {rw,mr,mw,m2r,br,src, alu_op, alu_ctrl, pc_src, imm_type, illegal}
    typedef struct {
        string      name;
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        logic [17:0] exp;
    } vec_t;

    localparam logic [17:0] NOP_ILL = {6'b000000, 2'b00, 4'b0010, 2'b00, 3'b111, 1'b1};

    vec_t vecs [35];

    function automatic logic [17:0] outs();
        return {reg_write, mem_read, mem_write, mem_to_reg, branch, alu_src,
                alu_op, alu_ctrl, pc_src, imm_type, illegal};
    endfunction

    task automatic check(input string name, input logic [17:0] act, input logic [17:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end else
            $display("ok   %s: %b", name, act);
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        check(name, {17'd0, act}, {17'd0, exp});
    endtask

    // Wait until the decode outputs reflect the inputs applied at a negedge.
    task automatic settle();
`ifdef CTRL_OUTREG_EN
        @(posedge clk);
`endif
        #1;
    endtask

    task automatic apply(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                         input logic v);
        @(negedge clk);
        opcode = op; funct3 = f3; funct7 = f7; instr_valid = v;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0]  = '{"R ADD",   7'b0110011, 3'b000, 7'b0000000, {6'b100000, 2'b10, 4'b0010, 2'b00, 3'b111, 1'b0}};
        vecs[1]  = '{"R SUB",   7'b0110011, 3'b000, 7'b0100000, {6'b100000, 2'b10, 4'b0110, 2'b00, 3'b111, 1'b0}};
        vecs[2]  = '{"R SLL",   7'b0110011, 3'b001, 7'b0000000, {6'b100000, 2'b10, 4'b0100, 2'b00, 3'b111, 1'b0}};
        vecs[3]  = '{"R SLT",   7'b0110011, 3'b010, 7'b0000000, {6'b100000, 2'b10, 4'b0111, 2'b00, 3'b111, 1'b0}};
        vecs[4]  = '{"R SLTU",  7'b0110011, 3'b011, 7'b0000000, {6'b100000, 2'b10, 4'b1001, 2'b00, 3'b111, 1'b0}};
        vecs[5]  = '{"R XOR",   7'b0110011, 3'b100, 7'b0000000, {6'b100000, 2'b10, 4'b0011, 2'b00, 3'b111, 1'b0}};
        vecs[6]  = '{"R SRL",   7'b0110011, 3'b101, 7'b0000000, {6'b100000, 2'b10, 4'b0101, 2'b00, 3'b111, 1'b0}};
        vecs[7]  = '{"R SRA",   7'b0110011, 3'b101, 7'b0100000, {6'b100000, 2'b10, 4'b1000, 2'b00, 3'b111, 1'b0}};
        vecs[8]  = '{"R OR",    7'b0110011, 3'b110, 7'b0000000, {6'b100000, 2'b10, 4'b0001, 2'b00, 3'b111, 1'b0}};
        vecs[9]  = '{"R AND",   7'b0110011, 3'b111, 7'b0000000, {6'b100000, 2'b10, 4'b0000, 2'b00, 3'b111, 1'b0}};
        vecs[10] = '{"R bad f7",      7'b0110011, 3'b000, 7'b0000001, NOP_ILL};
        vecs[11] = '{"R alt f7 AND",  7'b0110011, 3'b111, 7'b0100000, NOP_ILL};
        vecs[12] = '{"LW",      7'b0000011, 3'b010, 7'b1010101, {6'b110101, 2'b00, 4'b0010, 2'b00, 3'b000, 1'b0}};
        vecs[13] = '{"LOAD f3=011",   7'b0000011, 3'b011, 7'b0000000, NOP_ILL};
        vecs[14] = '{"LBU",     7'b0000011, 3'b100, 7'b0000000, {6'b110101, 2'b00, 4'b0010, 2'b00, 3'b000, 1'b0}};
        vecs[15] = '{"SW",      7'b0100011, 3'b010, 7'b0000000, {6'b001001, 2'b00, 4'b0010, 2'b00, 3'b001, 1'b0}};
        vecs[16] = '{"STORE f3=011",  7'b0100011, 3'b011, 7'b0000000, NOP_ILL};
        vecs[17] = '{"BEQ",     7'b1100011, 3'b000, 7'b0000000, {6'b000010, 2'b01, 4'b0110, 2'b01, 3'b010, 1'b0}};
        vecs[18] = '{"BNE",     7'b1100011, 3'b001, 7'b0000000, {6'b000010, 2'b01, 4'b0110, 2'b01, 3'b010, 1'b0}};
        vecs[19] = '{"BLT",     7'b1100011, 3'b100, 7'b0000000, {6'b000010, 2'b01, 4'b0111, 2'b01, 3'b010, 1'b0}};
        vecs[20] = '{"BLTU",    7'b1100011, 3'b110, 7'b0000000, {6'b000010, 2'b01, 4'b1001, 2'b01, 3'b010, 1'b0}};
        vecs[21] = '{"BRANCH f3=010", 7'b1100011, 3'b010, 7'b0000000, NOP_ILL};
        vecs[22] = '{"ADDI f7=0100000", 7'b0010011, 3'b000, 7'b0100000, {6'b100001, 2'b11, 4'b0010, 2'b00, 3'b000, 1'b0}};
        vecs[23] = '{"SRAI",    7'b0010011, 3'b101, 7'b0100000, {6'b100001, 2'b11, 4'b1000, 2'b00, 3'b000, 1'b0}};
        vecs[24] = '{"SLLI bad f7",   7'b0010011, 3'b001, 7'b0100000, NOP_ILL};
        vecs[25] = '{"SRLI bad f7",   7'b0010011, 3'b101, 7'b0000001, NOP_ILL};
        vecs[26] = '{"ORI any f7",    7'b0010011, 3'b110, 7'b1111111, {6'b100001, 2'b11, 4'b0001, 2'b00, 3'b000, 1'b0}};
        vecs[27] = '{"SLTIU",   7'b0010011, 3'b011, 7'b0000000, {6'b100001, 2'b11, 4'b1001, 2'b00, 3'b000, 1'b0}};
        vecs[28] = '{"JAL",     7'b1101111, 3'b101, 7'b0100000, {6'b100000, 2'b00, 4'b0010, 2'b01, 3'b100, 1'b0}};
        vecs[29] = '{"JALR",    7'b1100111, 3'b000, 7'b0000000, {6'b100001, 2'b00, 4'b0010, 2'b10, 3'b000, 1'b0}};
        vecs[30] = '{"JALR f3=001",   7'b1100111, 3'b001, 7'b0000000, NOP_ILL};
        vecs[31] = '{"LUI",     7'b0110111, 3'b111, 7'b0100000, {6'b100001, 2'b00, 4'b0010, 2'b00, 3'b011, 1'b0}};
        vecs[32] = '{"AUIPC",   7'b0010111, 3'b000, 7'b0000000, {6'b100001, 2'b00, 4'b0010, 2'b00, 3'b011, 1'b0}};
        vecs[33] = '{"opcode 1111111", 7'b1111111, 3'b000, 7'b0000000, NOP_ILL};
        vecs[34] = '{"opcode 0000000", 7'b0000000, 3'b000, 7'b0000000, NOP_ILL};

        // Reset with an illegal instruction asserted as valid.
        rst_n = 1'b0; opcode = 7'b1111111; funct3 = 3'b000; funct7 = 7'b0000000;
        instr_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check1("sticky held in reset", illegal_sticky, 1'b0);
`ifdef CTRL_OUTREG_EN
        check("outputs NOP in reset", outs(), {6'b000000, 2'b00, 4'b0010, 2'b00, 3'b111, 1'b0});
`endif
        @(negedge clk);
        instr_valid = 1'b0;
        rst_n = 1'b1;

        // Table: instr_valid low throughout so illegal entries must not latch.
        foreach (vecs[i]) begin
            apply(vecs[i].op, vecs[i].f3, vecs[i].f7, 1'b0);
            settle();
            check(vecs[i].name, outs(), vecs[i].exp);
        end
        @(posedge clk); #1;
        check1("sticky ignores invalid", illegal_sticky, 1'b0);

        // A valid legal instruction must not set the sticky flag.
        apply(7'b0110011, 3'b000, 7'b0000000, 1'b1);
        @(posedge clk); #1;
        check1("sticky legal valid", illegal_sticky, 1'b0);

        // Valid illegal instruction: flag rises on the next clock only.
        apply(7'b1111111, 3'b000, 7'b0000000, 1'b1);
`ifndef CTRL_OUTREG_EN
        #1;
        check1("illegal comb", illegal, 1'b1);
        check1("sticky before edge", illegal_sticky, 1'b0);
`endif
        @(posedge clk); #1;
        check1("sticky after edge", illegal_sticky, 1'b1);
`ifdef CTRL_OUTREG_EN
        check("illegal NOP reg", outs(), NOP_ILL);
`endif

        // Flag holds across later legal instructions.
        apply(7'b0000011, 3'b010, 7'b0000000, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        check1("sticky holds", illegal_sticky, 1'b1);

        // Asynchronous reset mid-cycle clears it immediately.
        #2;
        rst_n = 1'b0;
        #1;
        check1("sticky async clear", illegal_sticky, 1'b0);
`ifdef CTRL_OUTREG_EN
        check("async clear outputs", outs(), {6'b000000, 2'b00, 4'b0010, 2'b00, 3'b111, 1'b0});
`endif
        @(negedge clk);
        rst_n = 1'b1;
        instr_valid = 1'b0;

        // Latency: ADD then SUB.
        apply(7'b0110011, 3'b000, 7'b0000000, 1'b0);
        settle();
        apply(7'b0110011, 3'b000, 7'b0100000, 1'b0);
        #1;
`ifdef CTRL_OUTREG_EN
        check("SUB before edge", {14'd0, alu_ctrl}, {14'd0, 4'b0010});
        @(posedge clk); #1;
        check("SUB after edge", {14'd0, alu_ctrl}, {14'd0, 4'b0110});
`else
        check("SUB zero latency", {14'd0, alu_ctrl}, {14'd0, 4'b0110});
`endif

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/control_unit_top.md
CONTROL_UNIT_TOP -- requirements
Module: control_unit_top

Interface
REQ-001 SHALL define parameter/macro defaults: none; the single feature switch is described under Configuration.
REQ-002 clk  input  1  single clock, rising-edge active.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 opcode  input  7  instr[6:0].
REQ-005 funct3  input  3  instr[14:12].
REQ-006 funct7  input  7  instr[31:25].
REQ-007 instr_valid  input  1  qualifies the instruction for sticky illegal tracking.
REQ-008 reg_write, mem_read, mem_write, mem_to_reg, branch, alu_src  output  1 each  datapath enables/selects.
REQ-009 alu_op  output  2  00 add, 01 branch-compare, 10 R-type, 11 I-type ALU.
REQ-010 alu_ctrl  output  4  0000 AND, 0001 OR, 0010 ADD, 0011 XOR, 0100 SLL, 0101 SRL, 0110 SUB, 0111 SLT, 1000 SRA, 1001 SLTU.
REQ-011 pc_src  output  2  00 PC+4, 01 PC+imm, 10 ALU result.
REQ-012 imm_type  output  3  000 I, 001 S, 010 B, 011 U, 100 J, 111 none.
REQ-013 illegal  output  1  current instruction not decodable; illegal_sticky  output  1  latched illegal flag.

Function
REQ-014 Main decode (rw,mr,mw,m2r,br,src,alu_op,pc_src,imm_type): R 0110011=1,0,0,0,0,0,10,00,111; LOAD 0000011=1,1,0,1,0,1,00,00,000; STORE 0100011=0,0,1,0,0,1,00,00,001; BRANCH 1100011=0,0,0,0,1,0,01,01,010.
REQ-015 Cont.: OP-IMM 0010011=1,0,0,0,0,1,11,00,000; JAL 1101111=1,0,0,0,0,0,00,01,100; JALR 1100111=1,0,0,0,0,1,00,10,000; LUI 0110111 and AUIPC 0010111=1,0,0,0,0,1,00,00,011.
REQ-016 NOP value: all 1-bit outputs 0, alu_op 00, alu_ctrl 0010, pc_src 00, imm_type 111.
REQ-017 alu_op 00 -> alu_ctrl ADD regardless of funct fields.
REQ-018 alu_op 01 -> funct3 000/001 SUB, 100/101 SLT, 110/111 SLTU.
REQ-019 alu_op 10 -> funct3 000 ADD (funct7[5]=0) or SUB (=1); 001 SLL; 010 SLT; 011 SLTU; 100 XOR; 101 SRL/SRA by funct7[5]; 110 OR; 111 AND.
REQ-020 alu_op 11 -> as REQ-019 except funct3 000 always ADD.
REQ-021 illegal=1 for: unlisted opcode; R-type funct7 not 0000000/0100000, or 0100000 with funct3 not 000/101; OP-IMM funct3 001 with funct7≠0, or 101 with funct7 not 0000000/0100000; BRANCH funct3 010/011; LOAD funct3 011/110/111; STORE funct3 >010; JALR funct3≠000.
REQ-022 When illegal=1, all decode outputs SHALL take the NOP value.
REQ-023 illegal_sticky SHALL set on a rising clk when instr_valid=1 and illegal=1, and hold until reset.

Reset
REQ-024 rst_n low SHALL asynchronously clear illegal_sticky (and, with the macro, all registered outputs to NOP, illegal=0).
REQ-025 Release of rst_n SHALL take effect at the next rising clk; no other state exists.

Configuration
REQ-026 Macro CTRL_OUTREG_EN defined: all decode outputs and illegal registered on rising clk, one-cycle latency; undefined: purely combinational, zero latency, valid within the same delta step as the inputs.
REQ-027 illegal_sticky SHALL be registered in both builds, sampling the combinational illegal.

Verification
REQ-028 opcode 0110011, funct3 000, funct7 0000000 -> rw=1, src=0, alu_op 10, alu_ctrl 0010, imm_type 111; funct7 0100000 -> alu_ctrl 0110.
REQ-029 LOAD funct3 010 -> rw,mr,m2r,src=1, alu_ctrl 0010, imm 000; STORE funct3 010 -> mw=1, rw=0, imm 001.
REQ-030 BEQ -> br=1, alu_op 01, alu_ctrl 0110, pc_src 01, imm 010; ADDI -> alu_op 11, alu_ctrl 0010.
REQ-031 JAL -> pc_src 01, imm 100; JALR -> pc_src 10, src=1; LUI and AUIPC -> rw=1, imm 011, alu_ctrl 0010.
REQ-032 opcode 1111111 with instr_valid=1 -> illegal=1, NOP outputs, illegal_sticky=1 after next clk; assert rst_n low mid-cycle -> illegal_sticky=0 immediately.
REQ-033 With CTRL_OUTREG_EN: apply SUB, outputs update only after the next rising clk.
